calc_cmd_engine: RTL

- Downstream consumer of the UART receiver's RX_DATA byte stream; upstream producer for the UART transmitter's TX_START/TX_DATA.
- Parses ASCII expressions of the form "<A><op><B><TERM>" and evaluates them.
- A and B are unsigned decimal operands; op is one of + - * /.
- Transmits the decimal result, or an error token, back as ASCII bytes followed by CR LF.

---
 rtl/calc_cmd_engine.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/calc_cmd_engine.sv
// calc_cmd_engine: parses "<A><op><B><term>" ASCII expressions from a UART RX stream and returns the decimal result (or "E") plus CR LF over a UART TX handshake.
// Ports: i_clk clock; i_rst_n async active-low reset; i_rx_valid/i_rx_data received byte strobe;
//        i_tx_busy transmitter busy; o_tx_start/o_tx_data transmit request; o_ready high while accepting input.
module calc_cmd_engine #(
    parameter logic [7:0] TERM_CHAR = 8'h0D,
    parameter bit         ECHO      = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx_valid,
    input  logic [7:0] i_rx_data,
    input  logic       i_tx_busy,
    output logic       o_tx_start,
    output logic [7:0] o_tx_data,
    output logic       o_ready
);
    typedef enum logic [2:0] {S_OPA, S_OPB, S_ECHO, S_CALC, S_DIV, S_CONV, S_SEND, S_ERR} state_t;
    localparam logic [31:0] POW [10] = '{32'd1, 32'd10, 32'd100, 32'd1000, 32'd10000, 32'd100000,
                                          32'd1000000, 32'd10000000, 32'd100000000, 32'd1000000000};
    state_t      r_state, w_next, w_ret, w_proc;
    logic [15:0] r_a, r_b, r_quo, r_rem, w_sub;
    logic [1:0]  r_op, w_opcode, r_txph;
    logic        r_na, r_nb, r_err, r_ovf, r_neg, r_ret_b, r_tx_start;
    logic [31:0] r_mag;
    logic [3:0]  r_buf [10];
    logic [3:0]  r_dcnt, r_dig, r_pidx, r_pos, r_cnt;
    logic [7:0]  r_echo, r_tx_data, w_byte, w_tx_byte;
    logic        w_in_b, w_rx_ok, w_feed, w_digit, w_opc, w_term, w_skip, w_take_op;
    logic        w_tx_req, w_tx_done, w_last, w_ge, w_resp;
    logic [19:0] w_acc;
    logic [16:0] w_sh;
    // During an echo the held byte is processed in the context of the state it arrived in.
    assign w_in_b    = (r_state == S_OPB) || (r_state == S_ECHO && r_ret_b);
    assign w_rx_ok   = (r_state == S_OPA || r_state == S_OPB) && i_rx_valid;
    assign w_tx_done = (r_txph == 2'd2) && !i_tx_busy;
    assign w_feed    = (!ECHO && w_rx_ok) || (r_state == S_ECHO && w_tx_done);
    assign w_byte    = (r_state == S_ECHO) ? r_echo : i_rx_data;
    assign w_digit   = (w_byte >= 8'h30) && (w_byte <= 8'h39);
    assign w_opc     = w_byte inside {8'h2B, 8'h2D, 8'h2A, 8'h2F};
    assign w_opcode  = (w_byte == 8'h2B) ? 2'd0 : (w_byte == 8'h2D) ? 2'd1 : (w_byte == 8'h2A) ? 2'd2 : 2'd3;
    assign w_term    = (w_byte == TERM_CHAR) || (w_byte == 8'h3D);
    assign w_skip    = (w_byte == 8'h20) || (w_byte == 8'h0A);
    assign w_take_op = !w_in_b && w_opc && r_na;
    assign w_acc     = {4'd0, w_in_b ? r_b : r_a} * 20'd10 + {16'd0, w_byte[3:0]};
    assign w_ret     = w_in_b ? S_OPB : S_OPA;
    assign w_proc    = w_term ? ((w_in_b && r_nb && !r_err && !r_ovf) ? S_CALC : S_ERR) : w_take_op ? S_OPB : w_ret;
    // Restoring divider step: shift next dividend bit in, subtract when it fits.
    assign w_sh      = {r_rem, r_quo[15]};
    assign w_ge      = w_sh >= {1'b0, r_b};
    assign w_sub     = w_sh[15:0] - r_b;
    assign w_resp    = (r_state == S_SEND) || (r_state == S_ERR);
    assign w_tx_req  = w_resp || (r_state == S_ECHO);
    assign w_last    = (r_state == S_ERR) ? (r_pos == 4'd2) : (r_pos == r_dcnt + 4'd2);
    assign o_ready    = (r_state == S_OPA) || (r_state == S_OPB);
    assign o_tx_start = r_tx_start;
    assign o_tx_data  = r_tx_data;
    // Response byte at r_pos: SEND is '-', digits 1..r_dcnt, CR, LF; ERR is 'E', CR, LF.
    always_comb begin
        w_tx_byte = r_echo;
        if (r_state == S_ERR)
            w_tx_byte = (r_pos == 4'd0) ? 8'h45 : (r_pos == 4'd1) ? 8'h0D : 8'h0A;
        else if (r_state == S_SEND)
            w_tx_byte = (r_pos == 4'd0) ? 8'h2D : (r_pos <= r_dcnt) ? 8'h30 + {4'd0, r_buf[r_pos - 4'd1]} :
                        (r_pos == r_dcnt + 4'd1) ? 8'h0D : 8'h0A;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_OPA, S_OPB: if (i_rx_valid) w_next = ECHO ? S_ECHO : w_proc;
            S_ECHO:       if (w_tx_done) w_next = w_proc;
            S_CALC:       w_next = (r_op != 2'd3) ? S_CONV : (r_b == 16'd0) ? S_ERR : S_DIV;
            S_DIV:        if (r_cnt == 4'd15) w_next = S_CONV;
            S_CONV:       if (r_pidx == 4'd0 && r_mag == 32'd0) w_next = S_SEND;
            default:      if (w_tx_done && w_last) w_next = S_OPA;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_OPA;
        else          r_state <= w_next;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a <= '0; r_b <= '0; r_op <= '0; r_na <= 1'b0; r_nb <= 1'b0;
            r_err <= 1'b0; r_ovf <= 1'b0; r_neg <= 1'b0; r_ret_b <= 1'b0; r_echo <= '0;
            r_mag <= '0; r_quo <= '0; r_rem <= '0; r_cnt <= '0; r_buf <= '{default: 4'd0};
            r_dcnt <= '0; r_dig <= '0; r_pidx <= '0; r_pos <= '0;
            r_txph <= '0; r_tx_start <= 1'b0; r_tx_data <= '0;
        end else begin
            r_tx_start <= 1'b0;
            if (ECHO && w_rx_ok) begin
                r_echo  <= i_rx_data;
                r_ret_b <= (r_state == S_OPB);
            end
            if (w_feed) begin
                if (w_digit) begin
                    if (w_in_b) begin r_b <= w_acc[15:0]; r_nb <= 1'b1; end
                    else        begin r_a <= w_acc[15:0]; r_na <= 1'b1; end
                    if (w_acc > 20'd65535) r_ovf <= 1'b1;
                end else if (w_take_op) r_op <= w_opcode;
                else if (!w_term && !w_skip) r_err <= 1'b1;
            end
            if (r_state == S_CALC) begin
                r_neg  <= (r_op == 2'd1) && (r_a < r_b);
                r_mag  <= (r_op == 2'd0) ? {16'd0, r_a} + {16'd0, r_b} :
                          (r_op == 2'd1) ? ((r_a >= r_b) ? {16'd0, r_a - r_b} : {16'd0, r_b - r_a}) :
                          {16'd0, r_a} * {16'd0, r_b};
                r_quo  <= r_a; r_rem <= '0; r_cnt <= '0;
                r_pidx <= 4'd9; r_dig <= '0; r_dcnt <= '0;
            end
            if (r_state == S_DIV) begin
                r_rem <= w_ge ? w_sub : w_sh[15:0];
                r_quo <= {r_quo[14:0], w_ge};
                r_cnt <= r_cnt + 4'd1;
                r_mag <= {16'd0, r_quo[14:0], w_ge};
            end
            // One subtract or compare per cycle; a digit is stored once the current power no longer fits.
            if (r_state == S_CONV) begin
                if (r_mag >= POW[r_pidx]) begin
                    r_mag <= r_mag - POW[r_pidx];
                    r_dig <= r_dig + 4'd1;
                end else begin
                    if (r_dig != 4'd0 || r_dcnt != 4'd0 || r_pidx == 4'd0) begin
                        r_buf[r_dcnt] <= r_dig;
                        r_dcnt <= r_dcnt + 4'd1;
                    end
                    r_dig <= '0;
                    if (r_pidx != 4'd0) r_pidx <= r_pidx - 4'd1;
                end
            end
            if (w_next != r_state) r_pos <= (w_next == S_SEND && !r_neg) ? 4'd1 : 4'd0;
            else if (w_tx_done && w_resp) r_pos <= r_pos + 4'd1;
            if (w_tx_done && w_resp && w_last) begin
                r_a <= '0; r_b <= '0; r_op <= '0; r_na <= 1'b0; r_nb <= 1'b0;
                r_err <= 1'b0; r_ovf <= 1'b0; r_neg <= 1'b0;
            end
            // Handshake: issue when idle, then wait for busy to rise and fall before the next byte.
            case (r_txph)
                2'd0: if (w_tx_req && !i_tx_busy) begin
                    r_tx_start <= 1'b1;
                    r_tx_data  <= w_tx_byte;
                    r_txph     <= 2'd1;
                end
                2'd1: if (i_tx_busy) r_txph <= 2'd2;
                2'd2: if (!i_tx_busy) r_txph <= 2'd0;
                default: r_txph <= 2'd0;
            endcase
        end
    end
endmodule
